// File: rtl/vector_pkg.sv
// Shared types and default vectors for the 6502 reset/interrupt sequencer.
// Imported by vector_seq and its NMI edge detector.
package vector_pkg;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_D1   = 4'd1,
        S_D2   = 4'd2,
        S_PH   = 4'd3,
        S_PL   = 4'd4,
        S_PP   = 4'd5,
        S_VL   = 4'd6,
        S_VH   = 4'd7,
        S_IDLE = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        K_RESET = 2'd0,
        K_NMI   = 2'd1,
        K_IRQ   = 2'd2,
        K_BRK   = 2'd3
    } kind_t;

    localparam logic [15:0] DEF_VEC_NMI = 16'hFFFA;
    localparam logic [15:0] DEF_VEC_RST = 16'hFFFC;
    localparam logic [15:0] DEF_VEC_IRQ = 16'hFFFE;

    // A pending NMI redirects an IRQ/BRK sequence, never a reset one.
    function automatic logic [15:0] vec_base(
        input kind_t       k,
        input logic        pend,
        input logic [15:0] v_nmi,
        input logic [15:0] v_rst,
        input logic [15:0] v_irq
    );
        logic [15:0] b;
        b = v_irq;
        if (k == K_RESET) b = v_rst;
        else if (pend)    b = v_nmi;
        return b;
    endfunction

endpackage

// File: rtl/nmi_edge.sv
// Falling-edge detector for nmi_n with a pending flag.
// A new edge in the same cycle as the clear keeps the flag set.
module nmi_edge
    import vector_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic nmi_n,
    input  logic clr,
    output logic pend
);

    logic nmi_q;
    logic fall;

    assign fall = nmi_q & ~nmi_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_q <= 1'b1;
            pend  <= 1'b0;
        end else begin
            nmi_q <= nmi_n;
            if (fall)
                pend <= 1'b1;
            else if (clr)
                pend <= 1'b0;
        end
    end

endmodule

// File: rtl/vector_seq.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer: stack pushes, vector fetch,
// PC slice latch strobes. All outputs are registered.
module vector_seq
    import vector_pkg::*;
#(
    parameter logic [15:0] VEC_NMI = DEF_VEC_NMI,
    parameter logic [15:0] VEC_RST = DEF_VEC_RST,
    parameter logic [15:0] VEC_IRQ = DEF_VEC_IRQ
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        brk,
    output logic        busy,
    output logic        addr_ovr,
    output logic [15:0] vec_addr,
    output logic        latch_l,
    output logic        latch_h,
    output logic        push_pch,
    output logic        push_pcl,
    output logic        push_p,
    output logic        b_out,
    output logic        set_i
);

    state_t state;
    kind_t  kind;
    kind_t  take_kind;
    logic   take;
    logic   hijack;
    logic   nmi_pend;
    logic   nmi_clr;
    logic   do_push;

    nmi_edge u_nmi (
        .clk   (clk),
        .rst_n (rst_n),
        .nmi_n (nmi_n),
        .clr   (nmi_clr),
        .pend  (nmi_pend)
    );

    // Pending flag drops only once its vector has actually been fetched.
    assign nmi_clr = (state == S_VL) && hijack;
    assign do_push = (kind != K_RESET);

    always_comb begin
        take      = 1'b0;
        take_kind = K_BRK;
        if (nmi_pend) begin
            take      = 1'b1;
            take_kind = K_NMI;
        end else if (!irq_n && !i_flag) begin
            take      = 1'b1;
            take_kind = K_IRQ;
        end else if (brk) begin
            take      = 1'b1;
            take_kind = K_BRK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            kind     <= K_RESET;
            hijack   <= 1'b0;
            busy     <= 1'b1;
            addr_ovr <= 1'b0;
            vec_addr <= VEC_RST;
            latch_l  <= 1'b0;
            latch_h  <= 1'b0;
            push_pch <= 1'b0;
            push_pcl <= 1'b0;
            push_p   <= 1'b0;
            b_out    <= 1'b0;
            set_i    <= 1'b0;
        end else begin
            addr_ovr <= 1'b0;
            latch_l  <= 1'b0;
            latch_h  <= 1'b0;
            push_pch <= 1'b0;
            push_pcl <= 1'b0;
            push_p   <= 1'b0;
            b_out    <= 1'b0;
            set_i    <= 1'b0;
            unique case (state)
                S_RST: begin
                    state <= S_D1;
                    busy  <= 1'b1;
                end
                S_D1: begin
                    state <= S_D2;
                end
                S_D2: begin
                    state    <= S_PH;
                    push_pch <= do_push;
                end
                S_PH: begin
                    state    <= S_PL;
                    push_pcl <= do_push;
                end
                S_PL: begin
                    state  <= S_PP;
                    push_p <= do_push;
                    b_out  <= (kind == K_BRK);
                end
                S_PP: begin
                    state    <= S_VL;
                    addr_ovr <= 1'b1;
                    latch_l  <= 1'b1;
                    hijack   <= (kind != K_RESET) && nmi_pend;
                    vec_addr <= vec_base(kind, nmi_pend,
                                         VEC_NMI, VEC_RST, VEC_IRQ);
                end
                S_VL: begin
                    state    <= S_VH;
                    addr_ovr <= 1'b1;
                    latch_h  <= 1'b1;
                    set_i    <= 1'b1;
                    vec_addr <= vec_addr + 16'd1;
                end
                S_VH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_IDLE: begin
                    // The entry sync cycle is the first of the seven.
                    if (sync && take) begin
                        state <= S_D2;
                        kind  <= take_kind;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_RST;
                    kind  <= K_RESET;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/vector_seq.md
Name: vector_seq

Overview:
Reset/interrupt sequencer for the 6502 core. It is the writer that loads the program-counter byte slices.
- At reset release, and at an instruction boundary with a pending NMI or IRQ, it runs the 7-cycle 6502 entry sequence.
- It drives the stack-push strobes and overrides the address bus with the vector address.
- It strobes the PC low/high latches so the PC slices capture the vector bytes straight from the data bus.

Parameters:
VEC_NMI  16'hFFFA  NMI vector low-byte address
VEC_RST  16'hFFFC  reset vector low-byte address
VEC_IRQ  16'hFFFE  IRQ/BRK vector low-byte address

Ports:
clk       in   1   system clock
rst_n     in   1   asynchronous active-low reset
sync      in   1   core is at an opcode-fetch cycle (instruction boundary)
nmi_n     in   1   NMI request, falling-edge sensitive
irq_n     in   1   IRQ request, level sensitive, active low
i_flag    in   1   interrupt-disable flag from the status register
brk       in   1   BRK opcode decoded this sync cycle
busy      out  1   sequence in progress; core holds PC increment and decode
addr_ovr  out  1   address mux selects vec_addr instead of PC/stack
vec_addr  out  16  vector address being read
latch_l   out  1   PC low slice loads data bus this cycle
latch_h   out  1   PC high slice loads data bus this cycle
push_pch  out  1   write PCH to stack, SP decrement
push_pcl  out  1   write PCL to stack, SP decrement
push_p    out  1   write status to stack, SP decrement
b_out     out  1   B bit value for the pushed status (1 for BRK only)
set_i     out  1   set I flag (one-cycle pulse)

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- States: RST, D1, D2, PH, PL, PP, VL, VH, IDLE. Encoding 4-bit, in the package.
- While rst_n = 0:
  - state = RST, busy = 1.
  - All other outputs 0; vec_addr = VEC_RST.
  - nmi_pend = 0, nmi_q = 1, kind = RESET.
- Sequence, one state per clk: RST -> D1 -> D2 -> PH -> PL -> PP -> VL -> VH -> IDLE.
  - RST -> D1 on the first edge after release.
  - From IDLE, the cycle counted as "1" is the entry sync cycle, so entry->IDLE is 7 cycles.
- Entry from IDLE happens when sync = 1 and any of: nmi_pend, (irq_n = 0 and i_flag = 0), or brk.
  - Priority on entry: nmi_pend > IRQ > BRK.
  - kind is captured on entry. busy rises the cycle after the entry sync.
- Per-state outputs:
  - push_pch in PH, push_pcl in PL, push_p in PP. All three are suppressed (0) when kind = RESET (6502 dummy stack reads).
  - b_out = 1 in PP only when kind = BRK.
  - VL: addr_ovr = 1, vec_addr = base, latch_l = 1.
  - VH: addr_ovr = 1, vec_addr = base + 1, latch_h = 1, set_i = 1.
  - busy = 1 in all states except IDLE.
- Vector base is resolved at the start of VL, not on entry:
  - RESET -> VEC_RST.
  - else nmi_pend -> VEC_NMI (NMI hijack of IRQ/BRK).
  - else VEC_IRQ.
  - The base is held through VH. The +1 is a 16-bit add, no special wrap case.
- NMI detect:
  - nmi_q registers nmi_n every clk.
  - nmi_q = 1 and nmi_n = 0 sets nmi_pend.
  - nmi_pend clears at the VL->VH edge when base = VEC_NMI.
  - If a new falling edge occurs in the same cycle as the clear, set wins.
  - nmi_pend is not cleared by a RESET sequence unless reset is asserted.
- IRQ is sampled only at the entry sync. Deassertion later in the sequence has no effect.
- Requests arriving while busy:
  - IRQ/BRK are ignored.
  - NMI stays pending and is taken at the first sync after IDLE.
- Reset mid-sequence: immediate return to RST with outputs zeroed; the full reset sequence runs on release.
- sync while busy is ignored.

Decomposition:
- Package vector_pkg: state enum, kind enum (RESET/NMI/IRQ/BRK), default vector constants.
- Sub-module nmi_edge: registered falling-edge detector plus pending flop with set-priority clear.
- Remainder (FSM plus output decode) stays in vector_seq.

Test Plan:
- Reset release:
  - Stimulus: rst_n low 3 cycles then high; bench drives data FC on VL and 80 on VH into pcl/pch.
  - Required response: latch_l in cycle 6, latch_h in cycle 7 after release, vec_addr FFFC then FFFD, no push strobes, set_i in VH; PC = 16'h80FC; busy falls in cycle 8.
- IRQ taken:
  - Stimulus: i_flag = 0, irq_n = 0 at sync.
  - Required response: push_pch, push_pcl, push_p in consecutive cycles; b_out = 0; vec_addr FFFE then FFFF.
- IRQ masked:
  - Stimulus: i_flag = 1, irq_n = 0 at sync.
  - Required response: busy stays 0, no strobes.
- NMI hijack:
  - Stimulus: BRK at sync, then nmi_n falls during PH.
  - Required response: PP has b_out = 1; VL/VH use FFFA/FFFB; nmi_pend cleared; no second entry at the next sync.
- NMI during busy:
  - Stimulus: nmi_n falls during an IRQ VH cycle.
  - Required response: the IRQ completes to FFFE/FFFF; at the next sync an NMI sequence enters.
- Reset mid-sequence:
  - Stimulus: rst_n low during PL of an IRQ.
  - Required response: all strobes 0 immediately (async); after release, a 7-cycle reset sequence to FFFC/FFFD.
